// File: rtl/misr_response_analyzer_pkg.sv
// Shared BIST definitions: analyzer state encoding and the default MISR/LFSR
// width, feedback polynomial and seed, so both ends of the pattern path agree.
package misr_response_analyzer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_t;

  localparam int         DEF_WIDTH = 5;
  // x^5 + x^2 + 1: feedback is XORed into bits 2 and 0
  localparam logic [4:0] DEF_POLY  = 5'b00101;
  localparam logic [4:0] DEF_SEED  = 5'b00000;

endpackage

// File: rtl/misr_core.sv
// Multiple-input signature register: shift left with POLY feedback from the
// MSB, then XOR in the parallel data word. Load has priority over enable.
module misr_core
  import misr_response_analyzer_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic fb;
  assign fb = sig[WIDTH-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig <= RST_VAL;
    end else if (load) begin
      sig <= seed;
    end else if (enable) begin
      sig <= ({sig[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0)) ^ data;
    end
  end

endmodule

// File: rtl/misr_response_analyzer.sv
// BIST response analyzer: compacts PATTERN_COUNT CUT responses into a MISR,
// then compares the signature against golden and reports pass/fail.
module misr_response_analyzer
  import misr_response_analyzer_pkg::*;
#(
  parameter int               WIDTH         = DEF_WIDTH,
  parameter int               PATTERN_COUNT = 31,
  parameter logic [WIDTH-1:0] POLY          = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED          = WIDTH'(DEF_SEED),
  localparam int              CW            = $clog2(PATTERN_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_in,
  input  logic [WIDTH-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CW-1:0]    resp_count
);

  localparam logic [CW-1:0] LAST_IDX = CW'(PATTERN_COUNT - 1);

  bist_state_t state, state_nxt;
  logic        misr_load, misr_en;
  logic        cnt_clr, cnt_inc;
  logic        pass_clr, pass_upd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    pass_clr  = 1'b0;
    pass_upd  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nxt = ST_RUN;
          misr_load = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          misr_load = 1'b1;
          cnt_clr   = 1'b1;
          pass_clr  = 1'b1;
        end else if (resp_valid) begin
          misr_en = 1'b1;
          cnt_inc = 1'b1;
          // the final response is compacted on the same edge that enters CHECK
          if (resp_count == LAST_IDX) begin
            state_nxt = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          misr_load = 1'b1;
          cnt_clr   = 1'b1;
          pass_clr  = 1'b1;
        end else begin
          state_nxt = ST_DONE;
          pass_upd  = 1'b1;
        end
      end
      ST_DONE: begin
        if (start && !abort) begin
          state_nxt = ST_RUN;
          misr_load = 1'b1;
          cnt_clr   = 1'b1;
          pass_clr  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_count <= '0;
    end else if (cnt_clr) begin
      resp_count <= '0;
    end else if (cnt_inc) begin
      resp_count <= resp_count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass <= 1'b0;
    end else if (pass_clr) begin
      pass <= 1'b0;
    end else if (pass_upd) begin
      pass <= (signature == golden);
    end
  end

  misr_core #(
    .WIDTH   (WIDTH),
    .POLY    (POLY),
    .RST_VAL (SEED)
  ) u_misr (
    .clk    (clk),
    .rst    (rst),
    .load   (misr_load),
    .seed   (SEED),
    .enable (misr_en),
    .data   (resp_in),
    .sig    (signature)
  );

  // decoded straight from the state register, so no input reaches an output
  assign busy = (state == ST_RUN) || (state == ST_CHECK);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_misr_response_analyzer.sv
// Bench for misr_response_analyzer: three instances (1, 2 and 31 responses per
// run) share data inputs and are started one at a time through separate starts.
module tb_misr_response_analyzer;

  logic       clk = 1'b0;
  logic       rst, abort, resp_valid;
  logic       start1, start2, start31;
  logic [4:0] resp_in, golden;

  logic       busy1, done1, pass1;
  logic [4:0] sig1;
  logic [0:0] cnt1;
  logic       busy2, done2, pass2;
  logic [4:0] sig2;
  logic [1:0] cnt2;
  logic       busy31, done31, pass31;
  logic [4:0] sig31;
  logic [4:0] cnt31;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  misr_response_analyzer #(.PATTERN_COUNT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .resp_valid(resp_valid),
    .resp_in(resp_in), .golden(golden), .busy(busy1), .done(done1), .pass(pass1),
    .signature(sig1), .resp_count(cnt1));

  misr_response_analyzer #(.PATTERN_COUNT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort), .resp_valid(resp_valid),
    .resp_in(resp_in), .golden(golden), .busy(busy2), .done(done2), .pass(pass2),
    .signature(sig2), .resp_count(cnt2));

  misr_response_analyzer #(.PATTERN_COUNT(31)) dut31 (
    .clk(clk), .rst(rst), .start(start31), .abort(abort), .resp_valid(resp_valid),
    .resp_in(resp_in), .golden(golden), .busy(busy31), .done(done31), .pass(pass31),
    .signature(sig31), .resp_count(cnt31));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Signature as a GF(2) polynomial: multiply by x modulo x^5+x^2+1 (0x25),
  // then add the response word.
  logic [4:0] resp_q[$];
  function automatic logic [4:0] ref_sig();
    int s = 0;
    foreach (resp_q[i]) begin
      s = s * 2;
      if (s >= 32) s = s ^ 37;
      s = s ^ int'(resp_q[i]);
    end
    return 5'(s);
  endfunction

  typedef struct {
    logic [4:0] r0;
    logic [4:0] r1;
    logic [4:0] gold;
    logic [4:0] exp_sig;
    logic       exp_pass;
  } vec2_t;
  vec2_t vec2[5];

  task automatic full_run31(input bit use_lfsr, input bit good_gold);
    int lfsr = 1, i = 0, guard = 0, rises = 0, lat = 0;
    logic prev_done;
    logic [4:0] exp;
    resp_q.delete();
    for (int k = 0; k < 31; k++) begin
      if (use_lfsr) begin
        resp_q.push_back(5'(lfsr ^ (lfsr >> 1)));
        lfsr = ((lfsr << 1) & 31) | (((lfsr >> 4) ^ (lfsr >> 2)) & 1);
      end else begin
        resp_q.push_back(5'($urandom_range(0, 31)));
      end
    end
    exp    = ref_sig();
    golden = good_gold ? exp : exp ^ 5'(1 << $urandom_range(0, 4));
    start31 = 1'b1;
    @(negedge clk);
    start31   = 1'b0;
    prev_done = done31;
    while (i < 31 && guard < 500) begin
      if ($urandom_range(0, 3) == 0) begin
        resp_valid = 1'b0;
      end else begin
        resp_valid = 1'b1;
        resp_in    = resp_q[i];
        i++;
      end
      guard++;
      @(negedge clk);
      if (done31 && !prev_done) rises++;
      prev_done = done31;
    end
    resp_valid = 1'b0;
    check("full_count", 32'(cnt31), 32'd31);
    check("full_sig", 32'(sig31), 32'(exp));
    check("full_busy_check", 32'(busy31), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (done31 && !prev_done) rises++;
      prev_done = done31;
      if (done31 && lat == 0) lat = k;
    end
    check("full_done_latency", 32'(lat), 32'd1);
    check("full_done_once", 32'(rises), 32'd1);
    check("full_pass", 32'(pass31), 32'(good_gold));
    check("full_sig_hold", 32'(sig31), 32'(exp));
  endtask

  initial begin
    vec2[0] = '{5'b10000, 5'b00000, 5'b00101, 5'b00101, 1'b1};
    vec2[1] = '{5'b10000, 5'b00000, 5'b00100, 5'b00101, 1'b0};
    vec2[2] = '{5'b00001, 5'b00001, 5'b00011, 5'b00011, 1'b1};
    vec2[3] = '{5'b11111, 5'b10101, 5'b01110, 5'b01110, 1'b1};
    vec2[4] = '{5'b01010, 5'b11111, 5'b00000, 5'b01011, 1'b0};

    rst = 1'b0; abort = 1'b0; resp_valid = 1'b0;
    start1 = 1'b0; start2 = 1'b0; start31 = 1'b0;
    resp_in = '0; golden = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'({busy1, busy2, busy31}), 32'd0);
    check("rst_done", 32'({done1, done2, done31}), 32'd0);
    check("rst_pass", 32'({pass1, pass2, pass31}), 32'd0);
    check("rst_sig", 32'({sig1, sig2, sig31}), 32'd0);
    check("rst_cnt", 32'({cnt1, cnt2, cnt31}), 32'd0);
    rst = 1'b1;

    // single-response run
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("one_busy", 32'(busy1), 32'd1);
    resp_valid = 1'b1; resp_in = 5'b10110; golden = 5'b10110;
    @(negedge clk);
    resp_valid = 1'b0;
    check("one_sig", 32'(sig1), 32'h16);
    check("one_cnt", 32'(cnt1), 32'd1);
    check("one_done_early", 32'(done1), 32'd0);
    @(negedge clk);
    check("one_done", 32'(done1), 32'd1);
    check("one_pass", 32'(pass1), 32'd1);
    check("one_busy_off", 32'(busy1), 32'd0);

    // two-response table, each run restarting from DONE after the first
    for (int v = 0; v < 5; v++) begin
      golden = vec2[v].gold;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      check("t2_restart_pass", 32'(pass2), 32'd0);
      check("t2_restart_sig", 32'(sig2), 32'd0);
      resp_valid = 1'b1; resp_in = vec2[v].r0;
      @(negedge clk);
      check("t2_sig_first", 32'(sig2), 32'(vec2[v].r0));
      resp_in = vec2[v].r1;
      @(negedge clk);
      resp_valid = 1'b0;
      check("t2_sig", 32'(sig2), 32'(vec2[v].exp_sig));
      check("t2_cnt", 32'(cnt2), 32'd2);
      @(negedge clk);
      check("t2_done", 32'(done2), 32'd1);
      check("t2_pass", 32'(pass2), 32'(vec2[v].exp_pass));
    end

    // abort while in CHECK
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; resp_valid = 1'b1; resp_in = 5'b00111;
    repeat (2) @(negedge clk);
    resp_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("chk_abort_state", 32'({busy2, done2, pass2}), 32'd0);
    check("chk_abort_sig", 32'(sig2), 32'd0);

    // full-length runs with gaps
    full_run31(1'b1, 1'b1);
    full_run31(1'b0, 1'b0);
    full_run31(1'b0, 1'b1);

    // abort after ten responses
    start31 = 1'b1;
    @(negedge clk);
    start31 = 1'b0; resp_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      resp_in = 5'($urandom_range(1, 31));
      @(negedge clk);
    end
    resp_valid = 1'b0;
    check("abort_cnt_before", 32'(cnt31), 32'd10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_done", 32'({busy31, done31}), 32'd0);
    check("abort_sig", 32'(sig31), 32'd0);
    check("abort_cnt", 32'(cnt31), 32'd0);

    // start+abort together in IDLE: stays idle, responses ignored
    start31 = 1'b1; abort = 1'b1;
    @(negedge clk);
    start31 = 1'b0; abort = 1'b0; resp_valid = 1'b1; resp_in = 5'b11001;
    @(negedge clk);
    resp_valid = 1'b0;
    check("sa_idle_busy", 32'(busy31), 32'd0);
    check("sa_idle_sig", 32'({sig31, cnt31}), 32'd0);

    full_run31(1'b1, 1'b1);

    // start+abort in DONE has no effect; start alone restarts
    start31 = 1'b1; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("sa_done_held", 32'({done31, pass31}), 32'd3);
    @(negedge clk);
    start31 = 1'b0;
    check("restart_busy", 32'({busy31, done31}), 32'd2);
    check("restart_pass", 32'(pass31), 32'd0);
    check("restart_sig", 32'(sig31), 32'd0);

    // asynchronous reset between edges in RUN
    resp_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      resp_in = 5'($urandom_range(1, 31));
      @(negedge clk);
    end
    resp_valid = 1'b0;
    check("pre_rst_cnt", 32'(cnt31), 32'd3);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 32'({busy31, done31, pass31}), 32'd0);
    check("arst_sig", 32'({sig31, cnt31}), 32'd0);
    @(negedge clk);
    rst = 1'b1; resp_valid = 1'b1; resp_in = 5'b10101;
    repeat (3) @(negedge clk);
    resp_valid = 1'b0;
    check("post_rst_sig", 32'({sig31, cnt31}), 32'd0);
    check("post_rst_busy", 32'(busy31), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
